// File: rtl/reorder_buffer_mp.sv
// reorder_buffer_mp: circular reorder buffer with multi-port CDB writeback and in-order single retirement.
module reorder_buffer_mp #(
   parameter int DEPTH   = 8,
   parameter int NUM_CDB = 2,
   parameter int TAG_W   = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     alloc_valid,
   input  logic [31:0]              alloc_pc,
   input  logic [4:0]               alloc_rd,
   output logic                     alloc_ready,
   output logic [TAG_W-1:0]         alloc_tag,
   input  logic [NUM_CDB-1:0]       cdb_valid,
   input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
   input  logic [NUM_CDB*32-1:0]    cdb_value,
   output logic                     commit_valid,
   input  logic                     commit_ready,
   output logic [31:0]              commit_pc,
   output logic [4:0]               commit_rd,
   output logic [31:0]              commit_value,
   output logic                     empty,
   output logic                     full,
   output logic [TAG_W:0]           count
);
   logic [TAG_W:0]       head_q, head_d, tail_q, tail_d;
   logic [DEPTH-1:0]     busy_q, busy_d, done_q, done_d;
   logic [NUM_CDB-1:0]   cdb_ok;
   logic [31:0]          pc_q [DEPTH];
   logic [4:0]           rd_q [DEPTH];
   logic [31:0]          val_q [DEPTH];
   logic [TAG_W-1:0]     head_idx, tail_idx;
   logic                 do_alloc, do_retire;

   assign head_idx     = head_q[TAG_W-1:0];
   assign tail_idx     = tail_q[TAG_W-1:0];
   assign empty        = head_q == tail_q;
   assign full         = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);
   assign count        = tail_q - head_q;
   assign alloc_ready  = !full;
   assign alloc_tag    = tail_idx;
   assign commit_valid = !empty && done_q[head_idx];
   assign commit_pc    = pc_q[head_idx];
   assign commit_rd    = rd_q[head_idx];
   assign commit_value = val_q[head_idx];
   assign do_alloc     = alloc_valid && !full;
   assign do_retire    = commit_valid && commit_ready;

   // A result is accepted only for an entry that is live and still waiting; this also
   // rejects a result aimed at the slot being allocated on the same edge.
   always_comb begin
      for (int p = 0; p < NUM_CDB; p++)
         cdb_ok[p] = cdb_valid[p] && busy_q[cdb_tag[p*TAG_W +: TAG_W]] && !done_q[cdb_tag[p*TAG_W +: TAG_W]];
      busy_d = busy_q;
      done_d = done_q;
      head_d = head_q + {{TAG_W{1'b0}}, do_retire};
      tail_d = tail_q + {{TAG_W{1'b0}}, do_alloc};
      for (int p = 0; p < NUM_CDB; p++)
         if (cdb_ok[p]) done_d[cdb_tag[p*TAG_W +: TAG_W]] = 1'b1;
      if (do_retire) begin
         busy_d[head_idx] = 1'b0;
         done_d[head_idx] = 1'b0;
      end
      if (do_alloc) begin
         busy_d[tail_idx] = 1'b1;
         done_d[tail_idx] = 1'b0;
      end
      if (flush) begin
         busy_d = '0;
         done_d = '0;
         head_d = '0;
         tail_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_q <= '0;
         tail_q <= '0;
         busy_q <= '0;
         done_q <= '0;
      end else begin
         head_q <= head_d;
         tail_q <= tail_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   // Payloads are not reset; later ports overwrite earlier ones so the highest port wins.
   always_ff @(posedge clk) begin
      if (do_alloc && !flush) begin
         pc_q[tail_idx] <= alloc_pc;
         rd_q[tail_idx] <= alloc_rd;
      end
      for (int p = 0; p < NUM_CDB; p++)
         if (cdb_ok[p]) val_q[cdb_tag[p*TAG_W +: TAG_W]] <= cdb_value[p*32 +: 32];
   end
endmodule

// File: tb/tb_reorder_buffer_mp.sv
// tb_reorder_buffer_mp: scoreboard bench; allocations queue expected pc/rd/tag, retirements pop and compare.
module tb_reorder_buffer_mp;
   logic        clk = 1'b0;
   logic        rst, flush, alloc_valid, commit_ready;
   logic [31:0] alloc_pc;
   logic [4:0]  alloc_rd;
   logic        alloc_ready, commit_valid, empty, full;
   logic [2:0]  alloc_tag;
   logic [1:0]  cdb_valid;
   logic [5:0]  cdb_tag;
   logic [63:0] cdb_value;
   logic [31:0] commit_pc, commit_value;
   logic [4:0]  commit_rd;
   logic [3:0]  count;

   int errors = 0;
   int checks = 0;
   logic [31:0] q_pc[$];
   logic [4:0]  q_rd[$];
   int          q_tag[$];
   logic [31:0] m_val[8];
   int          mhead, mtail;

   reorder_buffer_mp dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_rd(alloc_rd),
      .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .commit_valid(commit_valid), .commit_ready(commit_ready),
      .commit_pc(commit_pc), .commit_rd(commit_rd), .commit_value(commit_value),
      .empty(empty), .full(full), .count(count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear;
      q_pc.delete();
      q_rd.delete();
      q_tag.delete();
      mhead = 0;
      mtail = 0;
   endtask

   task automatic do_flush;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      model_clear();
   endtask

   task automatic alloc(input logic [31:0] pc, input logic [4:0] rd);
      bit room;
      room = ((mtail - mhead + 16) % 16) < 8;
      alloc_valid = 1'b1;
      alloc_pc = pc;
      alloc_rd = rd;
      tick();
      alloc_valid = 1'b0;
      if (room) begin
         q_pc.push_back(pc);
         q_rd.push_back(rd);
         q_tag.push_back(mtail % 8);
         mtail = (mtail + 1) % 16;
      end
   endtask

   task automatic cdb1(input int tag, input logic [31:0] val);
      cdb_valid = 2'b01;
      cdb_tag = {3'd0, 3'(tag)};
      cdb_value = {32'd0, val};
      tick();
      cdb_valid = 2'b00;
      m_val[tag] = val;
   endtask

   task automatic cdb2(input int t0, input logic [31:0] v0, input int t1, input logic [31:0] v1);
      cdb_valid = 2'b11;
      cdb_tag = {3'(t1), 3'(t0)};
      cdb_value = {v1, v0};
      tick();
      cdb_valid = 2'b00;
      m_val[t0] = v0;
      m_val[t1] = v1;
   endtask

   task automatic pop_model;
      void'(q_pc.pop_front());
      void'(q_rd.pop_front());
      void'(q_tag.pop_front());
      mhead = (mhead + 1) % 16;
   endtask

   task automatic test_reset;
      checks++;
      if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0) begin
         errors++;
         $display("FAIL reset_flags: empty=%b full=%b count=%0d, expected 1 0 0", empty, full, count);
      end
      checks++;
      if (alloc_ready !== 1'b1 || alloc_tag !== 3'd0 || commit_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: alloc_ready=%b alloc_tag=%0d commit_valid=%b, expected 1 0 0", alloc_ready, alloc_tag, commit_valid);
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_single;
      alloc(32'h100, 5'd3);
      checks++;
      if (commit_valid !== 1'b0 || count !== 4'd1) begin
         errors++;
         $display("FAIL single_pending: commit_valid=%b count=%0d, expected 0 1", commit_valid, count);
      end
      commit_ready = 1'b1;
      cdb1(0, 32'hAA);
      checks++;
      if (commit_valid !== 1'b1 || commit_pc !== q_pc[0] || commit_rd !== q_rd[0] || commit_value !== m_val[q_tag[0]]) begin
         errors++;
         $display("FAIL single_commit: valid=%b pc=%h rd=%0d val=%h, expected 1 %h %0d %h", commit_valid, commit_pc, commit_rd, commit_value, q_pc[0], q_rd[0], m_val[q_tag[0]]);
      end
      tick();
      pop_model();
      commit_ready = 1'b0;
      checks++;
      if (empty !== 1'b1 || commit_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_empty: empty=%b commit_valid=%b, expected 1 0", empty, commit_valid);
      end
   endtask

   task automatic test_full;
      do_flush();
      for (int i = 0; i < 8; i++) alloc(32'h200 + 32'(i * 4), 5'(i + 8));
      checks++;
      if (full !== 1'b1 || count !== 4'd8 || alloc_ready !== 1'b0 || alloc_tag !== 3'd0) begin
         errors++;
         $display("FAIL full_flags: full=%b count=%0d ready=%b tag=%0d, expected 1 8 0 0", full, count, alloc_ready, alloc_tag);
      end
      alloc(32'hDEAD, 5'd31);
      checks++;
      if (full !== 1'b1 || count !== 4'd8 || alloc_tag !== 3'd0) begin
         errors++;
         $display("FAIL full_ninth: full=%b count=%0d tag=%0d, expected 1 8 0", full, count, alloc_tag);
      end
      for (int i = 0; i < 8; i += 2) cdb2(i, 32'h5000 + 32'(i), i + 1, 32'h6000 + 32'(i));
      commit_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (commit_valid !== 1'b1 || commit_pc !== q_pc[0] || commit_rd !== q_rd[0] || commit_value !== m_val[q_tag[0]]) begin
            errors++;
            $display("FAIL full_drain%0d: valid=%b pc=%h rd=%0d val=%h, expected 1 %h %0d %h", i, commit_valid, commit_pc, commit_rd, commit_value, q_pc[0], q_rd[0], m_val[q_tag[0]]);
         end
         tick();
         pop_model();
      end
      commit_ready = 1'b0;
      checks++;
      if (empty !== 1'b1 || count !== 4'd0) begin
         errors++;
         $display("FAIL full_drained: empty=%b count=%0d, expected 1 0", empty, count);
      end
   endtask

   task automatic test_out_of_order;
      int t0;
      t0 = mtail % 8;
      for (int i = 0; i < 3; i++) alloc(32'h300 + 32'(i * 4), 5'(i + 20));
      commit_ready = 1'b1;
      cdb1((t0 + 2) % 8, 32'hC2);
      checks++;
      if (commit_valid !== 1'b0) begin
         errors++;
         $display("FAIL ooo_wait2: commit_valid=%b, expected 0", commit_valid);
      end
      cdb1((t0 + 1) % 8, 32'hC1);
      checks++;
      if (commit_valid !== 1'b0) begin
         errors++;
         $display("FAIL ooo_wait1: commit_valid=%b, expected 0", commit_valid);
      end
      cdb1(t0, 32'hC0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (commit_valid !== 1'b1 || commit_pc !== q_pc[0] || commit_rd !== q_rd[0] || commit_value !== m_val[q_tag[0]]) begin
            errors++;
            $display("FAIL ooo_retire%0d: valid=%b pc=%h rd=%0d val=%h, expected 1 %h %0d %h", i, commit_valid, commit_pc, commit_rd, commit_value, q_pc[0], q_rd[0], m_val[q_tag[0]]);
         end
         tick();
         pop_model();
      end
      commit_ready = 1'b0;
      checks++;
      if (empty !== 1'b1) begin
         errors++;
         $display("FAIL ooo_empty: empty=%b, expected 1", empty);
      end
   endtask

   task automatic test_same_tag;
      do_flush();
      for (int i = 0; i < 5; i++) alloc(32'h400 + 32'(i * 4), 5'(i + 1));
      cdb2(4, 32'h11, 4, 32'h22);
      cdb2(0, 32'hA0, 1, 32'hA1);
      cdb2(2, 32'hA2, 3, 32'hA3);
      commit_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (commit_valid !== 1'b1 || commit_rd !== q_rd[0] || commit_value !== m_val[q_tag[0]]) begin
            errors++;
            $display("FAIL same_tag_retire%0d: valid=%b rd=%0d val=%h, expected 1 %0d %h", i, commit_valid, commit_rd, commit_value, q_rd[0], m_val[q_tag[0]]);
         end
         tick();
         pop_model();
      end
      commit_ready = 1'b0;
   endtask

   task automatic test_wrap;
      do_flush();
      for (int i = 0; i < 8; i++) alloc(32'h700 + 32'(i * 4), 5'(i + 2));
      cdb2(0, 32'hB0, 1, 32'hB1);
      cdb2(2, 32'hB2, 3, 32'hB3);
      commit_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (commit_valid !== 1'b1 || commit_pc !== q_pc[0] || commit_value !== m_val[q_tag[0]]) begin
            errors++;
            $display("FAIL wrap_retire%0d: valid=%b pc=%h val=%h, expected 1 %h %h", i, commit_valid, commit_pc, commit_value, q_pc[0], m_val[q_tag[0]]);
         end
         tick();
         pop_model();
      end
      commit_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (alloc_tag !== 3'(i)) begin
            errors++;
            $display("FAIL wrap_tag%0d: alloc_tag=%0d, expected %0d", i, alloc_tag, i);
         end
         alloc(32'h800 + 32'(i * 4), 5'(i + 16));
      end
      checks++;
      if (count !== 4'd8 || full !== 1'b1 || alloc_tag !== 3'd3) begin
         errors++;
         $display("FAIL wrap_full: count=%0d full=%b tag=%0d, expected 8 1 3", count, full, alloc_tag);
      end
      checks++;
      if (commit_valid !== 1'b1 || commit_pc !== q_pc[0] || commit_value !== m_val[q_tag[0]]) begin
         errors++;
         $display("FAIL wrap_head: valid=%b pc=%h val=%h, expected 1 %h %h", commit_valid, commit_pc, commit_value, q_pc[0], m_val[q_tag[0]]);
      end
      alloc_valid = 1'b1;
      alloc_pc = 32'hBAD;
      alloc_rd = 5'd30;
      commit_ready = 1'b1;
      tick();
      alloc_valid = 1'b0;
      commit_ready = 1'b0;
      pop_model();
      checks++;
      if (count !== 4'd7 || full !== 1'b0 || alloc_tag !== 3'd3) begin
         errors++;
         $display("FAIL wrap_blocked: count=%0d full=%b tag=%0d, expected 7 0 3", count, full, alloc_tag);
      end
   endtask

   task automatic test_flush_and_reset;
      do_flush();
      for (int i = 0; i < 5; i++) alloc(32'h900 + 32'(i * 4), 5'(i + 4));
      flush = 1'b1;
      alloc_valid = 1'b1;
      commit_ready = 1'b1;
      cdb_valid = 2'b11;
      cdb_tag = {3'd1, 3'd0};
      cdb_value = {32'h77, 32'h66};
      tick();
      flush = 1'b0;
      alloc_valid = 1'b0;
      commit_ready = 1'b0;
      cdb_valid = 2'b00;
      model_clear();
      checks++;
      if (empty !== 1'b1 || count !== 4'd0 || alloc_tag !== 3'd0 || commit_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_state: empty=%b count=%0d tag=%0d cv=%b, expected 1 0 0 0", empty, count, alloc_tag, commit_valid);
      end
      for (int i = 0; i < 3; i++) alloc(32'hA00 + 32'(i * 4), 5'(i + 9));
      cdb1(0, 32'hE0);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (empty !== 1'b1 || count !== 4'd0 || alloc_tag !== 3'd0 || commit_valid !== 1'b0 || alloc_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: empty=%b count=%0d tag=%0d cv=%b ready=%b, expected 1 0 0 0 1", empty, count, alloc_tag, commit_valid, alloc_ready);
      end
      #1 rst = 1'b1;
      model_clear();
      tick();
      alloc(32'hC00, 5'd7);
      commit_ready = 1'b1;
      cdb1(0, 32'hF00D);
      checks++;
      if (commit_valid !== 1'b1 || commit_pc !== q_pc[0] || commit_rd !== q_rd[0] || commit_value !== m_val[q_tag[0]]) begin
         errors++;
         $display("FAIL post_reset: valid=%b pc=%h rd=%0d val=%h, expected 1 %h %0d %h", commit_valid, commit_pc, commit_rd, commit_value, q_pc[0], q_rd[0], m_val[q_tag[0]]);
      end
      tick();
      pop_model();
      commit_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      flush = 1'b0;
      alloc_valid = 1'b0;
      alloc_pc = '0;
      alloc_rd = '0;
      cdb_valid = '0;
      cdb_tag = '0;
      cdb_value = '0;
      commit_ready = 1'b0;
      model_clear();
      for (int i = 0; i < 8; i++) m_val[i] = '0;
      #12;
      test_reset();
      test_single();
      test_full();
      test_out_of_order();
      test_same_tag();
      test_wrap();
      test_flush_and_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/reorder_buffer_mp.md
REORDER_BUFFER_MP -- requirements
Module: reorder_buffer_mp

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of ROB entries (power of two, >= 2).
REQ-002 SHALL have parameter NUM_CDB, default 2, number of result-writeback ports.
REQ-003 SHALL have parameter TAG_W, default $clog2(DEPTH), entry-index width.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flush  input  1  synchronous discard of all entries.
REQ-007 SHALL have port alloc_valid  input  1  decoder requests a new entry.
REQ-008 SHALL have port alloc_pc  input  32  instruction PC for new entry.
REQ-009 SHALL have port alloc_rd  input  5  destination register for new entry.
REQ-010 SHALL have port alloc_ready  output  1  entry available (equals !full).
REQ-011 SHALL have port alloc_tag  output  TAG_W  index the next allocation receives.
REQ-012 SHALL have port cdb_valid  input  NUM_CDB  per-port result valid.
REQ-013 SHALL have port cdb_tag  input  NUM_CDB*TAG_W  per-port target entry.
REQ-014 SHALL have port cdb_value  input  NUM_CDB*32  per-port result value.
REQ-015 SHALL have port commit_valid  output  1  head entry is done and may retire.
REQ-016 SHALL have port commit_ready  input  1  regfile accepts retirement.
REQ-017 SHALL have ports commit_pc/commit_rd/commit_value  output  32/5/32  head entry fields.
REQ-018 SHALL have ports empty, full  output  1 each; count  output  TAG_W+1  occupied entries.

Function
REQ-019 Storage SHALL be a circular buffer, head/tail pointers of TAG_W+1 bits (extra wrap bit); empty = pointers equal, full = indices equal and wrap bits differ.
REQ-020 Allocation SHALL occur on a rising edge with alloc_valid && !full: entry[tail] gets pc, rd, busy=1, done=0; tail increments modulo 2*DEPTH.
REQ-021 alloc_tag SHALL be tail index, combinational from registered state; alloc_valid while full SHALL be ignored, no state change.
REQ-022 Each CDB port with cdb_valid set SHALL, at the edge, write cdb_value to entry[cdb_tag] and set done=1, only if that entry is busy and not done; otherwise ignored.
REQ-023 Two CDB ports targeting the same tag in one cycle: the highest-numbered port SHALL win.
REQ-024 CDB to the tag being allocated in the same cycle SHALL be ignored (entry not yet busy).
REQ-025 commit_valid SHALL be !empty && entry[head].done, combinational; commit_* fields SHALL reflect entry[head].
REQ-026 Retirement SHALL occur on the edge with commit_valid && commit_ready: entry[head].busy=0, head increments; at most one retirement per cycle, strictly in allocation order.
REQ-027 A CDB write to the head entry SHALL make commit_valid rise the cycle after that edge (one-cycle writeback-to-commit latency).
REQ-028 Simultaneous allocation and retirement SHALL both take effect; count unchanged; full/empty judged on pre-edge state (alloc when full is blocked even if retiring).
REQ-029 count SHALL equal tail - head (modulo 2*DEPTH), updated each edge.
REQ-030 flush SHALL take priority over alloc, CDB and commit: at the edge all busy/done cleared, head=tail=0, count=0.
REQ-031 Pointer wrap-around SHALL be seamless; tag values reuse indices 0..DEPTH-1 in order.

Reset
REQ-032 rst low SHALL immediately (no clock) clear all busy/done bits, head=tail=0; outputs: empty=1, full=0, count=0, alloc_ready=1, alloc_tag=0, commit_valid=0.
REQ-033 Entry payloads (pc, rd, value) need not reset; commit_pc/rd/value are don't-care while commit_valid=0.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight entries, identical to power-on state after deassertion.

Verification (DEPTH=8, NUM_CDB=2)
REQ-035 Allocate 1 (pc=0x100, rd=3), CDB0 tag 0 value 0xAA, commit_ready=1 -> commit_valid high one cycle after CDB edge, commit_rd=3, commit_value=0xAA, then empty=1.
REQ-036 Allocate 8 -> full=1, count=8, alloc_ready=0; 9th alloc ignored; alloc_tag stays 0.
REQ-037 Allocate 3, CDB tags 2 then 1 then 0 -> no commit until tag 0 done; then retire 0,1,2 on consecutive cycles in order.
REQ-038 Both CDB ports target tag 4 same cycle (values 0x11, 0x22) -> entry 4 value 0x22.
REQ-039 Fill 8, retire 3, allocate 3 -> tags 0,1,2 reused, wrap bit toggled, count=8, full=1; when full, simultaneous retire + alloc -> alloc blocked, count=7.
REQ-040 Allocate 5 then flush with alloc_valid=1 and CDB active -> next cycle empty=1, count=0, alloc_tag=0; async rst pulse mid-traffic -> same state without clock edge.
